serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor; computes diff = a - b one bit per clock, LSB first.
- Datapath is a single full-adder cell with b inverted and carry-in preset to 1; the carry is held in a flop between bits.
- Serves as the sequential, area-minimal counterpart to the combinational ripple-carry adder chain in the arithmetic library.
- Uses a start/busy/done handshake, so it can be driven directly by a controller FSM.

Parameters:
- WIDTH, 4: operand and result width in bits (>= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge when the unit is in IDLE or DONE.
- a  input  WIDTH  minuend; sampled only on an accepted start.
- b  input  WIDTH  subtrahend; sampled only on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a result is valid.
- diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
- borrow_out  output  1  registered; 1 iff a < b (unsigned).

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, busy=0, done=0, diff=0, borrow_out=0, and clears the shift registers, bit counter and carry flop. Reset during RUN abandons the operation, and no done pulse follows.
- State IDLE: busy=0, done=0. start=1 at edge E0 -> latch a, b into shift registers; carry<=1; counter<=0; go to RUN.
- State RUN: each edge processes bit i = counter:
  - s = a_i ^ ~b_i ^ carry
  - carry <= (a_i & ~b_i) | (carry & (a_i ^ ~b_i))
  - s is shifted into the result shift register from the MSB end; operands shift right by 1; counter increments.
- RUN lasts exactly WIDTH cycles. On the edge processing bit WIDTH-1, diff and borrow_out are loaded (borrow_out = ~final carry) and the state moves to DONE.
- State DONE: lasts exactly 1 cycle, with done=1 and busy=0.
  - start=1 in DONE is accepted, with the same action as in IDLE, allowing back-to-back operations.
  - Otherwise the state returns to IDLE.
- Latency: if start is accepted at edge E0, busy is high for cycles E0+1 .. E0+WIDTH and done is high in cycle E0+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start in RUN is ignored; no queuing, no error flag.
- Changes on a/b after start is accepted have no effect.
- diff/borrow_out change only on completion or reset, and hold their value indefinitely in IDLE.
- Width rules:
  - diff is always WIDTH bits and wraps modulo 2^WIDTH.
  - a == b gives diff=0, borrow_out=0.
  - b == 0 gives diff=a, borrow_out=0.
- Implementation: states are encoded as localparams; outputs come directly from flops with no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside diff and reset to 0.
  - ovf = 1 iff the two's-complement interpretation of a - b overflows, i.e. (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Equivalently, ovf is the carry into the MSB XOR the carry out of the MSB, captured on the final RUN edge.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=1011, b=1010, pulse start -> busy high 4 cycles, done pulse in cycle 5, diff=0001, borrow_out=0.
- a=1010, b=1011 -> diff=1111, borrow_out=1. Then a=0000, b=0001 issued with start asserted during the DONE cycle -> accepted back-to-back, diff=1111, borrow_out=1 exactly 5 cycles later.
- a=0110, b=0110 -> diff=0000, borrow_out=0. Then a=0110, b=0000 -> diff=0110, borrow_out=0. Also change a/b mid-RUN -> result unaffected.
- start during RUN (a=1111, b=0001 in flight, second start with a=0000) -> ignored, single done, diff=1110, borrow_out=0.
- Drop rst_n in the 2nd RUN cycle -> immediate busy=0, diff=0000, borrow_out=0, no done pulse. After release, a normal operation with a=1001, b=0011 gives diff=0110.
- With SERIAL_SUBTRACTOR_OVF_EN:
  - a=1000, b=0001 -> diff=0111, ovf=1, borrow_out=0.
  - a=0111, b=1111 -> diff=1000, ovf=1, borrow_out=1.
  - a=0011, b=0001 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-adder cell with start/busy/done.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             a_bit, nb_bit, sum_bit, carry_nx, last;
    logic [WIDTH-1:0] shifted;

    // Full-adder cell computing a + ~b + carry for the current bit
    always_comb begin
        a_bit    = a_q[0];
        nb_bit   = ~b_q[0];
        sum_bit  = a_bit ^ nb_bit ^ carry_q;
        carry_nx = (a_bit & nb_bit) | (carry_q & (a_bit ^ nb_bit));
        shifted  = {sum_bit, res_q};
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = done_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = shifted[WIDTH-1:1];
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    diff_d   = shifted;
                    borrow_d = ~carry_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // carry into the MSB is the incoming carry of the last bit
                    ovf_d    = carry_q ^ carry_nx;
`endif
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand sequences, random ops.
// Build with SERIAL_SUBTRACTOR_OVF_EN to also check ovf.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a_in),
        .b          (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int sa, sb, sd;
        v.a  = a;
        v.b  = b;
        v.d  = W'((int'(a) - int'(b)) & ((1 << W) - 1));
        v.br = (int'(a) < int'(b));
        sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd   = sa - sb;
        v.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return v;
    endfunction

    // Drive start for one edge; returns at the first RUN cycle's negedge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks busy for W cycles then the done cycle; returns in the done cycle
    task automatic wait_done(input string name, input vec_t e);
        bit bad;
        bad = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        chk({name, "_busy"}, {31'd0, bad}, 32'd0);
        @(negedge clk);
        chk({name, "_done"}, {30'd0, done, busy}, 32'd2);
        chk({name, "_diff"}, 32'(diff), 32'(e.d));
        chk({name, "_borrow"}, {31'd0, borrow_out}, {31'd0, e.br});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
`endif
    endtask

    vec_t vecs[10];
    vec_t e;
    int   ndone;
    logic [W-1:0] cap_d;
    logic         cap_b;

    initial begin
        vecs[0] = '{4'b1011, 4'b1010, 4'b0001, 1'b0, 1'b0};
        vecs[1] = '{4'b1010, 4'b1011, 4'b1111, 1'b1, 1'b0};
        vecs[2] = '{4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{4'b0110, 4'b0000, 4'b0110, 1'b0, 1'b0};
        vecs[4] = '{4'b1001, 4'b0011, 4'b0110, 1'b0, 1'b1};
        vecs[5] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
        vecs[6] = '{4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b1};
        vecs[7] = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0};
        vecs[9] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0};

        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_done_low", i), {31'd0, done}, 32'd0);
        end

        // Hold in IDLE
        repeat (3) @(negedge clk);
        chk("hold_diff", 32'(diff), 32'(vecs[9].d));
        chk("hold_borrow", {31'd0, borrow_out}, {31'd0, vecs[9].br});

        // Back-to-back: start asserted during the DONE cycle
        launch(4'b1010, 4'b1011);
        wait_done("b2b_a", vecs[1]);
        launch(4'b0000, 4'b0001);
        wait_done("b2b_b", vecs[9]);
        @(negedge clk);

        // Operands change mid-RUN
        launch(4'b0110, 4'b0000);
        a_in = 4'b1111;
        b_in = 4'b1111;
        wait_done("midrun", vecs[3]);
        @(negedge clk);

        // start during RUN is ignored
        launch(4'b1111, 4'b0001);
        @(negedge clk);
        start = 1'b1;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap_d = 'x;
        cap_b = 1'bx;
        for (int k = 0; k < 2 * W + 4; k++) begin
            if (done === 1'b1) begin
                ndone++;
                cap_d = diff;
                cap_b = borrow_out;
            end
            @(negedge clk);
        end
        chk("ignore_ndone", 32'(ndone), 32'd1);
        chk("ignore_diff", 32'(cap_d), 32'(4'b1110));
        chk("ignore_borrow", {31'd0, cap_b}, 32'd0);

        // Reset in the 2nd RUN cycle
        launch(4'b1011, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        launch(4'b1001, 4'b0011);
        wait_done("post_rst", vecs[4]);
        @(negedge clk);

        // Random operations against the arithmetic model
        for (int n = 0; n < 60; n++) begin
            e = model(W'($urandom), W'($urandom));
            launch(e.a, e.b);
            if ($urandom_range(0, 1) == 1) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            wait_done($sformatf("rnd%0d", n), e);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
